miriscv_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the core data bus, downstream of the top-level address decode.
- Claims data accesses that fall outside RAM; the top qualifies data_req_i with its own decode.
- Buffers bytes in a small FIFO and serialises them 8N1, LSB first, on tx_o, with a programmable bit period.
- Register reads are combinational, matching the single-cycle RAM read timing the core expects.

---
 rtl/miriscv_uart_tx_if.sv | 20 ++
 rtl/miriscv_uart_tx.sv | 195 +++++++++++++++++++
 tb/tb_miriscv_uart_tx.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/miriscv_uart_tx_if.sv
// Core data-bus slice seen by the memory-mapped UART transmitter.
// The master drives the access; the slave returns combinational read data.
interface miriscv_uart_tx_if;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;

  modport master (
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_rdata_o
  );

  modport slave (
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_rdata_o
  );
endinterface

// File: rtl/miriscv_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO and programmable bit period.
// Define UART_TX_PARITY_EN to insert an even-parity bit and advertise it in STATUS bit8.
module miriscv_uart_tx #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  miriscv_uart_tx_if.slave bus,
  output logic             tx_o,
  output logic             busy_o
);

  localparam int unsigned   PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned   CW       = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  localparam logic PAR_CAP = 1'b1;
`else
  localparam logic PAR_CAP = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e state_q, state_d;

  // Bus decode
  logic [1:0] reg_sel;
  logic       wr_en;
  logic       push_req;
  logic       div_wr;
  logic       ovf_clr;

  assign reg_sel  = bus.data_addr_i[3:2];
  assign wr_en    = bus.data_req_i & bus.data_we_i;
  assign push_req = wr_en & (reg_sel == 2'd0) & bus.data_be_i[0];
  assign div_wr   = wr_en & (reg_sel == 2'd2);
  assign ovf_clr  = wr_en & (reg_sel == 2'd1) & bus.data_be_i[0] & bus.data_wdata_i[3];

  // TX FIFO
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_full, fifo_empty, push_ok, pop, overflow;

  assign fifo_full  = (fifo_cnt == FULL_CNT);
  assign fifo_empty = (fifo_cnt == '0);
  assign push_ok    = push_req & ~fifo_full;

  always_ff @(posedge clk_i) begin
    if (push_ok) fifo_mem[wr_ptr] <= bus.data_wdata_i[7:0];
  end

  // A push while full is dropped even when a pop frees a slot on the same edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: ;
      endcase
      if (push_req & fifo_full) overflow <= 1'b1;
      else if (ovf_clr)         overflow <= 1'b0;
    end
  end

  // Bit-period divider register; a zero divider would stall the line, so it becomes 1.
  logic [15:0] div_q, div_new;

  always_comb begin
    div_new = div_q;
    if (bus.data_be_i[0]) div_new[7:0]  = bus.data_wdata_i[7:0];
    if (bus.data_be_i[1]) div_new[15:8] = bus.data_wdata_i[15:8];
    if (div_new == '0)    div_new       = 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)    div_q <= DEFAULT_DIV;
    else if (div_wr) div_q <= div_new;
  end

  // Serialiser datapath
  logic [15:0] tick_cnt;
  logic [7:0]  shift_q;
  logic [2:0]  bit_idx;
  logic        parity_q;
  logic        tick;

  assign tick = (tick_cnt == '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tick_cnt <= '0;
      shift_q  <= '0;
      bit_idx  <= '0;
      parity_q <= 1'b0;
    end else if (pop) begin
      shift_q  <= fifo_mem[rd_ptr];
      parity_q <= ^fifo_mem[rd_ptr];
      tick_cnt <= div_q - 1'b1;
      bit_idx  <= '0;
    end else if (state_q != S_IDLE) begin
      if (tick) begin
        tick_cnt <= div_q - 1'b1;
        if (state_q == S_DATA) begin
          shift_q <= shift_q >> 1;
          bit_idx <= bit_idx + 1'b1;
        end
      end else begin
        tick_cnt <= tick_cnt - 1'b1;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!fifo_empty) state_d = S_START;
      S_START: if (tick) state_d = S_DATA;
      S_DATA: begin
        if (tick && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (tick) state_d = S_STOP;
`endif
      S_STOP:  if (tick) state_d = fifo_empty ? S_IDLE : S_START;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs; the STOP->START pop keeps consecutive frames gap-free
  always_comb begin
    tx_o   = 1'b1;
    pop    = 1'b0;
    busy_o = (state_q != S_IDLE) | ~fifo_empty;
    case (state_q)
      S_IDLE:   pop  = ~fifo_empty;
      S_START:  tx_o = 1'b0;
      S_DATA:   tx_o = shift_q[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_o = parity_q;
`endif
      S_STOP:   pop  = tick & ~fifo_empty;
      default:  ;
    endcase
  end

  // Register read mux
  logic [3:0]  cnt_sat;
  logic [31:0] status;

  always_comb begin
    cnt_sat = (32'(fifo_cnt) > 32'd15) ? 4'hF : 4'(fifo_cnt);
    status  = {23'b0, PAR_CAP, cnt_sat, overflow, fifo_empty, fifo_full, busy_o};
    case (reg_sel)
      2'd1:    bus.data_rdata_o = status;
      2'd2:    bus.data_rdata_o = {16'b0, div_q};
      default: bus.data_rdata_o = '0;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{bus.data_addr_i[31:4], bus.data_addr_i[1:0],
                         bus.data_be_i[3:2], bus.data_wdata_i[31:16]};

endmodule

// File: tb/tb_miriscv_uart_tx.sv
// Self-checking bench for miriscv_uart_tx: random bytes and dividers checked against
// an expected line waveform built frame by frame from the byte list.
module tb_miriscv_uart_tx;

  localparam int unsigned DEPTH   = 4;
  localparam logic [15:0] DEF_DIV = 16'd868;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned FB  = 11;
  localparam logic [31:0] CAP = 32'h100;
`else
  localparam int unsigned FB  = 10;
  localparam logic [31:0] CAP = 32'h000;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx, busy;

  miriscv_uart_tx_if bus ();

  miriscv_uart_tx #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(DEF_DIV)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus),
    .tx_o   (tx),
    .busy_o (busy)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [7:0] wr_bytes[$];
  logic [7:0] exp_bytes[$];
  logic       tx_s[$];
  logic       busy_s[$];

  // Line level of bit position idx within the frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int unsigned idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[3'(idx - 1)];
    if (FB == 11 && idx == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    @(negedge clk);
    bus.data_req_i   = 1'b1;
    bus.data_we_i    = 1'b1;
    bus.data_addr_i  = addr;
    bus.data_wdata_i = data;
    bus.data_be_i    = be;
    @(negedge clk);
    bus.data_req_i = 1'b0;
    bus.data_we_i  = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    bus.data_req_i  = 1'b1;
    bus.data_we_i   = 1'b0;
    bus.data_addr_i = addr;
    #1;
    data = bus.data_rdata_o;
    bus.data_req_i = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    bus_read(addr, rd);
    n_cmp++;
    if (rd !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, rd, exp);
    end
  endtask

  // Writes wr_bytes on consecutive cycles and checks the resulting line waveform.
  // ovf_case assumes frames far longer than the burst, so only one pop lands inside it.
  task automatic stream_test(input string name, input int unsigned div, input bit ovf_case);
    int unsigned n, n_acc, len, bad, first_bad;
    n = wr_bytes.size();
    n_acc = (ovf_case && n > DEPTH + 1) ? DEPTH + 1 : n;
    exp_bytes.delete();
    for (int unsigned i = 0; i < n_acc; i++) exp_bytes.push_back(wr_bytes[i]);
    len = n_acc * FB * div;
    tx_s.delete();
    busy_s.delete();
    fork
      begin
        for (int unsigned i = 0; i < n; i++) begin
          @(negedge clk);
          bus.data_req_i   = 1'b1;
          bus.data_we_i    = 1'b1;
          bus.data_addr_i  = 32'h0;
          bus.data_be_i    = {3'($urandom), 1'b1};
          bus.data_wdata_i = {24'($urandom), wr_bytes[i]};
        end
        @(negedge clk);
        bus.data_we_i  = 1'b0;
        bus.data_req_i = 1'b0;
        if (ovf_case) begin
          int unsigned cnt;
          logic [31:0] exp_st;
          cnt = n_acc - 1;
          exp_st = CAP | 32'h1 | ((cnt == DEPTH) ? 32'h2 : 32'h0) | ((cnt == 0) ? 32'h4 : 32'h0)
                 | ((n > DEPTH + 1) ? 32'h8 : 32'h0) | ((cnt > 15 ? 32'd15 : cnt) << 4);
          bus.data_req_i  = 1'b1;
          bus.data_addr_i = 32'h4;
          #1;
          n_cmp++;
          if (bus.data_rdata_o !== exp_st) begin
            n_bad++;
            $display("FAIL %s status_after_burst: got 0x%08h expected 0x%08h", name, bus.data_rdata_o, exp_st);
          end
          bus.data_req_i = 1'b0;
        end
      end
      begin
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (tx !== 1'b1) begin
          n_bad++;
          $display("FAIL %s pre_start: tx=%b expected 1", name, tx);
        end
        for (int unsigned k = 0; k <= len; k++) begin
          @(negedge clk);
          tx_s.push_back(tx);
          busy_s.push_back(busy);
        end
      end
    join

    bad = 0;
    first_bad = 0;
    for (int unsigned k = 0; k < len; k++) begin
      logic e;
      e = frame_bit(exp_bytes[k / (FB * div)], (k % (FB * div)) / div);
      if (tx_s[k] !== e) begin
        if (bad == 0) first_bad = k;
        bad++;
      end
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL %s waveform: %0d wrong cycles, first at %0d (got %b expected %b)", name, bad,
               first_bad, tx_s[first_bad],
               frame_bit(exp_bytes[first_bad / (FB * div)], (first_bad % (FB * div)) / div));
    end

    for (int unsigned f = 0; f < n_acc; f++) begin
      logic [7:0] got;
      for (int unsigned j = 0; j < 8; j++)
        got[j] = tx_s[f * FB * div + (1 + j) * div + div / 2];
      n_cmp++;
      if (got !== exp_bytes[f]) begin
        n_bad++;
        $display("FAIL %s byte%0d: got 0x%02h expected 0x%02h", name, f, got, exp_bytes[f]);
      end
    end

    n_cmp++;
    if (busy_s[len - 1] !== 1'b1 || busy_s[len] !== 1'b0 || tx_s[len] !== 1'b1) begin
      n_bad++;
      $display("FAIL %s frame_end: busy[%0d]=%b busy[%0d]=%b tx=%b expected 1,0,1", name,
               len - 1, busy_s[len - 1], len, busy_s[len], tx_s[len]);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_lines: tx=%b busy=%b expected 1,0", tx, busy);
    end
    check_reg("reset_status", 32'h4, 32'h4 | CAP);
    check_reg("reset_div", 32'h8, {16'b0, DEF_DIV});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    int unsigned changes = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) changes++;
    end
    n_cmp++;
    if (changes != 0) begin
      n_bad++;
      $display("FAIL idle_hold: %0d cycles off idle, expected 0", changes);
    end
  endtask

  task automatic test_regs();
    logic [15:0] r;
    logic [7:0]  h;
    r = 16'($urandom) | 16'h0001;
    h = 8'($urandom);
    bus_write(32'h8, {16'($urandom), r}, 4'b0011);
    check_reg("div_full_write", 32'h8, {16'b0, r});
    bus_write(32'h8, {16'($urandom), h, 8'($urandom)}, 4'b0010);
    check_reg("div_upper_lane", 32'h8, {16'b0, h, r[7:0]});
    bus_write(32'hC, 32'hFFFF_FFFF, 4'b1111);
    check_reg("reserved_read", 32'hC, 32'h0);
    check_reg("txdata_read", 32'h0, 32'h0);
    check_reg("status_after_regs", 32'h4, 32'h4 | CAP);
  endtask

  task automatic test_single();
    bus_write(32'h8, 32'd4, 4'b0011);
    wr_bytes = '{8'h55};
    stream_test("single_55", 4, 1'b0);
  endtask

  task automatic test_back_to_back();
    bus_write(32'h8, 32'd2, 4'b0011);
    wr_bytes = '{8'hA3, 8'h0F};
    stream_test("back_to_back", 2, 1'b0);
  endtask

  task automatic test_overflow();
    bus_write(32'h8, 32'd100, 4'b0011);
    wr_bytes.delete();
    repeat (6) wr_bytes.push_back(8'($urandom));
    stream_test("overflow", 100, 1'b1);
    check_reg("ovf_sticky", 32'h4, 32'h4 | 32'h8 | CAP);
    bus_write(32'h4, 32'h08, 4'b0001);
    check_reg("ovf_cleared", 32'h4, 32'h4 | CAP);
  endtask

  task automatic test_min_div();
    bus_write(32'h8, 32'd0, 4'b0011);
    check_reg("div_zero_is_one", 32'h8, 32'd1);
    wr_bytes = '{8'($urandom)};
    stream_test("div_one", 1, 1'b0);
  endtask

  task automatic test_random();
    for (int unsigned it = 0; it < 4; it++) begin
      int unsigned div, n;
      div = $urandom_range(6, 1);
      n   = $urandom_range(4, 1);
      bus_write(32'h8, div, 4'b0011);
      wr_bytes.delete();
      repeat (n) wr_bytes.push_back(8'($urandom));
      stream_test($sformatf("random%0d", it), div, 1'b0);
    end
  endtask

  task automatic test_ignored_write();
    bus_write(32'h0, 32'h0000_00AA, 4'b1110);
    repeat (5) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      n_bad++;
      $display("FAIL be0_clear_ignored: busy=%b tx=%b expected 0,1", busy, tx);
    end
  endtask

  task automatic test_parity();
    bus_write(32'h8, 32'd3, 4'b0011);
    wr_bytes = '{8'h07};
    stream_test("parity_07", 3, 1'b0);
    check_reg("status_cap", 32'h4, 32'h4 | CAP);
  endtask

  task automatic test_reset_midframe();
    bus_write(32'h8, 32'd50, 4'b0011);
    bus_write(32'h0, 32'h0000_0012, 4'b0001);
    bus_write(32'h0, 32'h0000_0034, 4'b0001);
    repeat (20) @(negedge clk);
    n_cmp++;
    if (tx !== 1'b0) begin
      n_bad++;
      $display("FAIL midframe_start_bit: tx=%b expected 0", tx);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset_lines: tx=%b busy=%b expected 1,0", tx, busy);
    end
    check_reg("midreset_status", 32'h4, 32'h4 | CAP);
    check_reg("midreset_div", 32'h8, {16'b0, DEF_DIV});
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int unsigned active = 0;
      repeat (20) begin
        @(negedge clk);
        if (tx !== 1'b1 || busy !== 1'b0) active++;
      end
      n_cmp++;
      if (active != 0) begin
        n_bad++;
        $display("FAIL queue_flushed: %0d active cycles after reset, expected 0", active);
      end
    end
  endtask

  initial begin
    bus.data_req_i   = 1'b0;
    bus.data_we_i    = 1'b0;
    bus.data_be_i    = '0;
    bus.data_addr_i  = '0;
    bus.data_wdata_i = '0;
    test_reset();
    test_idle();
    test_regs();
    test_single();
    test_back_to_back();
    test_overflow();
    test_min_div();
    test_random();
    test_ignored_write();
    test_parity();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
